// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out path and the PSDRAM line fetcher.
package vga_pkg;

  localparam int HLINES = 640;
  localparam int VLINES = 480;
  localparam int HMAX   = HLINES - 1;
  localparam int VMAX   = VLINES - 1;

  localparam int ADR_W = 23;
  localparam int DAT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/line_addr_gen.sv
// PSDRAM word address of the first pixel pair of a line.
module line_addr_gen #(
  parameter int                         LINE_WORDS = vga_pkg::HLINES / 2,
  parameter logic [vga_pkg::ADR_W-1:0]  BASE_ADR   = '0
) (
  input  logic [8:0]                line,
  output logic [vga_pkg::ADR_W-1:0] adr
);
  import vga_pkg::*;

  logic [ADR_W-1:0] line_w;
  logic [ADR_W-1:0] offset;

  assign line_w = {{(ADR_W-9){1'b0}}, line};

  // 320 = 256 + 64, so the default geometry needs no multiplier
  generate
    if (LINE_WORDS == 320) begin : g_shift
      assign offset = (line_w << 8) + (line_w << 6);
    end else begin : g_mul
      assign offset = line_w * ADR_W'(LINE_WORDS);
    end
  endgenerate

  assign adr = BASE_ADR + offset;

endmodule

// File: rtl/psram_line_fetch.sv
// Fetches one display line from PSDRAM by asynchronous word reads and
// writes it byte-serially (even pixel = low byte) into the scan-out line buffer.
module psram_line_fetch #(
  parameter int                        HLINES   = vga_pkg::HLINES,
  parameter int                        VLINES   = vga_pkg::VLINES,
  parameter int                        RD_WAIT  = 4,
  parameter logic [vga_pkg::ADR_W-1:0] BASE_ADR = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        line_req,
  input  logic [8:0]                  line_num,
  input  logic [vga_pkg::DAT_W-1:0]   MemDataIn,
  output logic [vga_pkg::ADR_W-1:0]   MemAdr,
  output logic                        MemOE,
  output logic                        MemWR,
  output logic                        RamCE,
  output logic                        RamLB,
  output logic                        RamUB,
  output logic                        wr_en,
  output logic [9:0]                  wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic                        bad_line
);
  import vga_pkg::*;

  localparam int         WORDS     = HLINES / 2;
  localparam int         CW        = $clog2(RD_WAIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(RD_WAIT - 1);
  localparam logic [8:0]    WORD_LAST = 9'(WORDS - 1);
  localparam logic [8:0]    LINE_LAST = 9'(VLINES - 1);

  state_t           state;
  logic [8:0]       line_q;
  logic [8:0]       word_idx;
  logic [8:0]       wr_word;
  logic [CW-1:0]    cnt;
  logic [DAT_W-1:0] word_q;
  logic [1:0]       wpend;
  logic             drain_ph;
  logic [8:0]       sel_line;
  logic [ADR_W-1:0] line_base;

  // In IDLE the base address must already reflect the incoming request
  assign sel_line = (state == ST_IDLE) ? line_num : line_q;

  line_addr_gen #(
    .LINE_WORDS (WORDS),
    .BASE_ADR   (BASE_ADR)
  ) u_line_addr_gen (
    .line (sel_line),
    .adr  (line_base)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      line_q   <= '0;
      word_idx <= '0;
      wr_word  <= '0;
      cnt      <= '0;
      word_q   <= '0;
      wpend    <= 2'd0;
      drain_ph <= 1'b0;
      MemAdr   <= '0;
      MemOE    <= 1'b1;
      MemWR    <= 1'b1;
      RamCE    <= 1'b1;
      RamLB    <= 1'b0;
      RamUB    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      bad_line <= 1'b0;
    end else begin
      MemWR <= 1'b1;
      RamLB <= 1'b0;
      RamUB <= 1'b0;
      done  <= 1'b0;

      // Two-beat byte writer; runs under the next word's wait time
      case (wpend)
        2'd1: begin
          wr_en   <= 1'b1;
          wr_addr <= {wr_word, 1'b0};
          wr_data <= word_q[7:0];
          wpend   <= 2'd2;
        end
        2'd2: begin
          wr_en   <= 1'b1;
          wr_addr <= {wr_word, 1'b1};
          wr_data <= word_q[15:8];
          wpend   <= 2'd0;
        end
        default: wr_en <= 1'b0;
      endcase

      if (line_req && (state != ST_IDLE))
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          busy  <= 1'b0;
          RamCE <= 1'b1;
          MemOE <= 1'b1;
          if (line_req) begin
            if (line_num <= LINE_LAST) begin
              line_q   <= line_num;
              word_idx <= '0;
              cnt      <= '0;
              MemAdr   <= line_base;
              busy     <= 1'b1;
              RamCE    <= 1'b0;
              MemOE    <= 1'b0;
              state    <= ST_READ;
            end else begin
              bad_line <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            word_q  <= MemDataIn;
            wr_word <= word_idx;
            wpend   <= 2'd1;
            if (word_idx == WORD_LAST) begin
              drain_ph <= 1'b0;
              state    <= ST_DRAIN;
            end else begin
              word_idx <= word_idx + 9'd1;
              MemAdr   <= line_base + {{(ADR_W-9){1'b0}}, word_idx} + ADR_W'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          RamCE    <= 1'b1;
          MemOE    <= 1'b1;
          drain_ph <= 1'b1;
          if (drain_ph)
            state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_line_fetch.sv
// Randomised bench for psram_line_fetch with a PSDRAM model and a line-buffer reference.
module tb_psram_line_fetch;

  localparam int NPIX = 640;
  localparam int NWRD = 320;

  logic        clk = 1'b0;
  logic        reset, line_req, line_req2;
  logic [8:0]  line_num, line_num2;
  logic [15:0] mem_data, mem_data2;

  logic [22:0] MemAdr, MemAdr2;
  logic        MemOE, MemWR, RamCE, RamLB, RamUB, wr_en, busy, done, overrun, bad_line;
  logic        MemOE2, MemWR2, RamCE2, RamLB2, RamUB2, wr_en2, busy2, done2, overrun2, bad_line2;
  logic [9:0]  wr_addr, wr_addr2;
  logic [7:0]  wr_data, wr_data2;

  int          pat, pat2;
  logic [15:0] salt, salt2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // PSDRAM contents as a function of word address
  function automatic logic [15:0] mem_word(input logic [22:0] a, input int pt, input logic [15:0] s);
    logic [7:0] lo;
    if (pt == 0) begin
      lo = a[7:0];
      return {lo + 8'd1, lo};
    end
    return (a[15:0] * 16'h9E37) ^ {9'd0, a[22:16]} ^ s;
  endfunction

  function automatic logic [7:0] exp_byte(input int line, input int p, input int pt, input logic [15:0] s);
    int          wi;
    logic [15:0] w;
    wi = line * NWRD + p / 2;
    w  = mem_word(23'(wi), pt, s);
    return (p % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  function automatic int pixel_errs(input logic [7:0] b[NPIX], input int line, input int pt, input logic [15:0] s);
    int e;
    e = 0;
    for (int p = 0; p < NPIX; p++)
      if (b[p] !== exp_byte(line, p, pt, s)) e++;
    return e;
  endfunction

  always_comb mem_data  = mem_word(MemAdr, pat, salt);
  always_comb mem_data2 = mem_word(MemAdr2, pat2, salt2);

  psram_line_fetch #(.RD_WAIT(4)) dut (
    .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num), .MemDataIn(mem_data),
    .MemAdr(MemAdr), .MemOE(MemOE), .MemWR(MemWR), .RamCE(RamCE), .RamLB(RamLB), .RamUB(RamUB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overrun(overrun), .bad_line(bad_line)
  );

  psram_line_fetch #(.RD_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .line_req(line_req2), .line_num(line_num2), .MemDataIn(mem_data2),
    .MemAdr(MemAdr2), .MemOE(MemOE2), .MemWR(MemWR2), .RamCE(RamCE2), .RamLB(RamLB2), .RamUB(RamUB2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2), .done(done2),
    .overrun(overrun2), .bad_line(bad_line2)
  );

  // Observation state collected every cycle, 1 time unit after the edge
  int         cyc = 0;
  int         n_wr, last_wa, order_err, n_done, done_cyc, n_busy, first_ce, last_ce, adr_min, adr_max, first_adr;
  logic       prev_ce = 1'b1;
  logic [7:0] lb[NPIX];
  int         n_wr2, last_wa2, order_err2, n_done2, done2_cyc, first_wr2, last_wr2;
  logic [7:0] lb2[NPIX];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      if (int'(wr_addr) < NPIX) lb[wr_addr] = wr_data;
      else order_err++;
      if (int'(wr_addr) != last_wa + 1) order_err++;
      last_wa = int'(wr_addr);
      n_wr++;
    end
    if (RamCE === 1'b0) begin
      if (prev_ce) begin
        first_ce  = cyc;
        first_adr = int'(MemAdr);
      end
      last_ce = cyc;
      if (int'(MemAdr) < adr_min) adr_min = int'(MemAdr);
      if (int'(MemAdr) > adr_max) adr_max = int'(MemAdr);
    end
    prev_ce = (RamCE !== 1'b0);
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) n_busy++;
    if (wr_en2 === 1'b1) begin
      if (int'(wr_addr2) < NPIX) lb2[wr_addr2] = wr_data2;
      if (int'(wr_addr2) != last_wa2 + 1) order_err2++;
      last_wa2 = int'(wr_addr2);
      if (n_wr2 == 0) first_wr2 = cyc;
      last_wr2 = cyc;
      n_wr2++;
    end
    if (done2 === 1'b1) begin
      n_done2++;
      done2_cyc = cyc;
    end
  end

  task automatic clear_mon();
    n_wr = 0; last_wa = -1; order_err = 0; n_done = 0; done_cyc = -1; n_busy = 0;
    first_ce = -1; last_ce = -1; adr_min = 32'h7fffffff; adr_max = -1; first_adr = -1;
    for (int p = 0; p < NPIX; p++) lb[p] = 'x;
  endtask

  task automatic clear_mon2();
    n_wr2 = 0; last_wa2 = -1; order_err2 = 0; n_done2 = 0; done2_cyc = -1; first_wr2 = -1; last_wr2 = -1;
    for (int p = 0; p < NPIX; p++) lb2[p] = 'x;
  endtask

  task automatic req(input int line, output int t);
    @(negedge clk);
    line_req = 1'b1;
    line_num = 9'(line);
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      @(posedge clk);
      #2;
      i++;
    end
    ok = (n_done != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; line_req = 1'b0; line_num = '0; line_req2 = 1'b0; line_num2 = '0;
    pat = 0; salt = '0; pat2 = 0; salt2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({MemOE, MemWR, RamCE, RamLB, RamUB, wr_en, busy, done, overrun, bad_line} !== 10'b1110000000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, expected 1110000000",
               {MemOE, MemWR, RamCE, RamLB, RamUB, wr_en, busy, done, overrun, bad_line});
    end
    n_checks++;
    if (MemAdr !== 23'd0) begin n_fail++; $display("FAIL reset_adr: got %0d, expected 0", MemAdr); end
    n_checks++;
    if ({wr_addr, wr_data} !== 18'd0) begin
      n_fail++; $display("FAIL reset_wr: got addr %0d data %0d, expected 0 0", wr_addr, wr_data);
    end
    n_checks++;
    if ({MemOE2, MemWR2, RamCE2, RamLB2, RamUB2, wr_en2, busy2, done2, overrun2, bad_line2} !== 10'b1110000000) begin
      n_fail++; $display("FAIL reset_ctl2: got %b, expected 1110000000",
                         {MemOE2, MemWR2, RamCE2, RamLB2, RamUB2, wr_en2, busy2, done2, overrun2, bad_line2});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_line0();
    int t; bit ok; int e;
    clear_mon(); pat = 0; salt = '0;
    req(0, t);
    wait_done(2000, ok);
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL line0_timeout: no done within 2000 cycles"); end
    n_checks++;
    if (done_cyc - t != 1283) begin n_fail++; $display("FAIL line0_done_lat: got %0d, expected 1283", done_cyc - t); end
    n_checks++;
    if (n_wr != NPIX) begin n_fail++; $display("FAIL line0_nwr: got %0d, expected %0d", n_wr, NPIX); end
    n_checks++;
    if (order_err != 0) begin n_fail++; $display("FAIL line0_order: got %0d bad addresses, expected 0", order_err); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL line0_ndone: got %0d, expected 1", n_done); end
    e = pixel_errs(lb, 0, 0, '0);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL line0_pixels: got %0d wrong pixels, expected 0", e); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL line0_busy_end: got %b, expected 0", busy); end
    n_checks++;
    if (first_adr != 0) begin n_fail++; $display("FAIL line0_first_adr: got %0d, expected 0", first_adr); end
  endtask

  task automatic test_line479();
    int t; bit ok; int e;
    clear_mon(); pat = 1; salt = 16'($urandom);
    req(479, t);
    wait_done(2000, ok);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL l479_timeout: no done within 2000 cycles"); end
    n_checks++;
    if (first_adr != 153280 || first_ce != t) begin
      n_fail++; $display("FAIL l479_first: got adr %0d at +%0d, expected 153280 at +0", first_adr, first_ce - t);
    end
    n_checks++;
    if (adr_min != 153280 || adr_max != 153599) begin
      n_fail++; $display("FAIL l479_range: got %0d..%0d, expected 153280..153599", adr_min, adr_max);
    end
    n_checks++;
    if (last_ce - t != 1280) begin n_fail++; $display("FAIL l479_ce_end: got +%0d, expected +1280", last_ce - t); end
    e = pixel_errs(lb, 479, pat, salt);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL l479_pixels: got %0d wrong pixels, expected 0", e); end
  endtask

  task automatic test_random_lines();
    int t; bit ok; int e; int line;
    for (int k = 0; k < 3; k++) begin
      clear_mon(); pat = 1; salt = 16'($urandom);
      line = $urandom_range(0, 479);
      req(line, t);
      wait_done(2000, ok);
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (!ok || done_cyc - t != 1283) begin
        n_fail++; $display("FAIL rnd_done_lat line %0d: got %0d, expected 1283", line, done_cyc - t);
      end
      n_checks++;
      if (first_adr != line * NWRD || adr_max != line * NWRD + NWRD - 1) begin
        n_fail++; $display("FAIL rnd_adr line %0d: got %0d..%0d, expected %0d..%0d",
                           line, first_adr, adr_max, line * NWRD, line * NWRD + NWRD - 1);
      end
      e = pixel_errs(lb, line, pat, salt);
      n_checks++;
      if (e != 0 || n_wr != NPIX) begin
        n_fail++; $display("FAIL rnd_pixels line %0d: got %0d wrong, %0d writes, expected 0 wrong, 640 writes", line, e, n_wr);
      end
    end
  endtask

  task automatic test_overrun();
    int t; bit ok; int e;
    clear_mon(); pat = 1; salt = 16'($urandom);
    req(5, t);
    repeat (99) @(posedge clk);
    @(negedge clk);
    line_req = 1'b1; line_num = 9'd6;
    @(negedge clk);
    line_req = 1'b0;
    wait_done(2000, ok);
    repeat (10) @(posedge clk);
    #2;
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, expected 1", overrun); end
    n_checks++;
    if (adr_min < 1600 || adr_max > 1919) begin
      n_fail++; $display("FAIL ovr_range: got %0d..%0d, expected within 1600..1919", adr_min, adr_max);
    end
    n_checks++;
    if (!ok || n_done != 1 || done_cyc - t != 1283) begin
      n_fail++; $display("FAIL ovr_done: got %0d pulses at +%0d, expected 1 at +1283", n_done, done_cyc - t);
    end
    e = pixel_errs(lb, 5, pat, salt);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL ovr_pixels: got %0d wrong pixels, expected 0", e); end
  endtask

  task automatic test_bad_line();
    int t; int line;
    clear_mon();
    line = $urandom_range(480, 511);
    req(line, t);
    repeat (20) @(posedge clk);
    #2;
    n_checks++;
    if (bad_line !== 1'b1) begin n_fail++; $display("FAIL bad_flag line %0d: got %b, expected 1", line, bad_line); end
    n_checks++;
    if (n_busy != 0 || first_ce != -1 || n_wr != 0) begin
      n_fail++; $display("FAIL bad_activity: got busy %0d ce %0d wr %0d, expected 0 -1 0", n_busy, first_ce, n_wr);
    end
  endtask

  task automatic test_reset_mid();
    int t; bit ok; int e;
    clear_mon(); pat = 1; salt = 16'($urandom);
    req(10, t);
    repeat (599) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({RamCE, MemOE, wr_en, busy, done, overrun, bad_line} !== 7'b1100000) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b, expected 1100000",
                         {RamCE, MemOE, wr_en, busy, done, overrun, bad_line});
    end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d, expected 0", n_done); end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    line_req = 1'b1; line_num = 9'd11;
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    line_req = 1'b0;
    wait_done(2000, ok);
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (first_adr != 3520 || first_ce != t) begin
      n_fail++; $display("FAIL rstmid_first: got adr %0d at +%0d, expected 3520 at +0", first_adr, first_ce - t);
    end
    n_checks++;
    if (!ok || n_done != 1 || done_cyc - t != 1283) begin
      n_fail++; $display("FAIL rstmid_done: got %0d pulses at +%0d, expected 1 at +1283", n_done, done_cyc - t);
    end
    e = pixel_errs(lb, 11, pat, salt);
    n_checks++;
    if (e != 0 || n_wr != NPIX) begin
      n_fail++; $display("FAIL rstmid_pixels: got %0d wrong, %0d writes, expected 0 wrong, 640 writes", e, n_wr);
    end
  endtask

  task automatic test_back_to_back();
    int t; bit ok; int e; int la; int lb_line;
    la = $urandom_range(0, 479);
    lb_line = $urandom_range(0, 479);
    clear_mon(); pat = 1; salt = 16'($urandom);
    req(la, t);
    wait_done(2000, ok);
    e = pixel_errs(lb, la, pat, salt);
    n_checks++;
    if (!ok || done_cyc - t != 1283 || e != 0) begin
      n_fail++; $display("FAIL b2b_first: got done +%0d, %0d wrong pixels, expected +1283, 0", done_cyc - t, e);
    end
    @(negedge clk);
    clear_mon();
    line_req = 1'b1; line_num = 9'(lb_line);
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    line_req = 1'b0;
    wait_done(2000, ok);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (!ok || first_adr != lb_line * NWRD || done_cyc - t != 1283) begin
      n_fail++; $display("FAIL b2b_second: got adr %0d done +%0d, expected %0d +1283", first_adr, done_cyc - t, lb_line * NWRD);
    end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
    e = pixel_errs(lb, lb_line, pat, salt);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL b2b_pixels: got %0d wrong pixels, expected 0", e); end
  endtask

  task automatic test_rdwait2();
    int t; int i; int e;
    clear_mon2(); pat2 = 0; salt2 = '0;
    @(negedge clk);
    line_req2 = 1'b1; line_num2 = 9'd1;
    @(posedge clk);
    #1 t = cyc;
    @(negedge clk);
    line_req2 = 1'b0;
    i = 0;
    while (n_done2 == 0 && i < 1000) begin
      @(posedge clk);
      #2;
      i++;
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (n_done2 != 1 || done2_cyc - t != 643) begin
      n_fail++; $display("FAIL rw2_done: got %0d pulses at +%0d, expected 1 at +643", n_done2, done2_cyc - t);
    end
    n_checks++;
    if (n_wr2 != NPIX || last_wr2 - first_wr2 != NPIX - 1 || first_wr2 - t != 3) begin
      n_fail++; $display("FAIL rw2_gapless: got %0d writes over +%0d..+%0d, expected 640 over +3..+642",
                         n_wr2, first_wr2 - t, last_wr2 - t);
    end
    n_checks++;
    if (order_err2 != 0) begin n_fail++; $display("FAIL rw2_order: got %0d bad addresses, expected 0", order_err2); end
    e = pixel_errs(lb2, 1, 0, '0);
    n_checks++;
    if (e != 0) begin n_fail++; $display("FAIL rw2_pixels: got %0d wrong pixels, expected 0", e); end
  endtask

  initial begin
    clear_mon();
    clear_mon2();
    test_reset();
    test_line0();
    test_line479();
    test_random_lines();
    test_overrun();
    test_bad_line();
    test_reset_mid();
    test_back_to_back();
    test_rdwait2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
